// File: rtl/alu_pkg.sv
// Shared ALU definitions: adder/subtractor op encodings and the N/Z/C/V flag bundle.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub; the producer/consumer side uses master.
interface cla_pipe_addsub_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    flags_t           flags;

    modport master (
        output in_valid, a, b, op, ci, out_ready,
        input  in_ready, out_valid, s, flags
    );

    modport slave (
        input  in_valid, a, b, op, ci, out_ready,
        output in_ready, out_valid, s, flags
    );

endinterface

// File: rtl/cla_grp4.sv
// Combinational 4-bit carry-lookahead group; c3_o is the carry into bit 3 (used for overflow).
module cla_grp4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o,
    output logic       c3_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = ci_i;
    assign c[1] = g[0] | (p[0] & ci_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci_i);
    assign co_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci_i);

    assign s_o  = p ^ c;
    assign c3_o = c[3];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor: stage k resolves slice k, operands shift down and sums
// shift in from the top so the final stage holds a right-aligned full-width result.
module cla_pipe_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    cla_pipe_addsub_if.slave bus
);

    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned NG = SW / 4;

    if (STAGES < 1 || (WIDTH % (4 * STAGES)) != 0) begin : g_bad_cfg
        $error("cla_pipe_addsub: need STAGES >= 1 and WIDTH a multiple of 4*STAGES");
    end

    logic             en;
    logic             out_vld;
    logic             cy_fin;
    logic             cmsb_q;
    logic [WIDTH-1:0] s_fin;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // A held result at the output stalls every stage.
    assign en           = !(out_vld && !bus.out_ready);
    assign bus.in_ready = en;

    always_comb begin
        b_eff   = bus.b;
        cin_eff = 1'b0;
        unique case (bus.op)
            OP_ADD: begin
                b_eff   = bus.b;
                cin_eff = 1'b0;
            end
            OP_SUB: begin
                b_eff   = ~bus.b;
                cin_eff = 1'b1;
            end
            OP_ADC: cin_eff = bus.ci;
            OP_SBC: begin
                b_eff   = ~bus.b;
                cin_eff = bus.ci;
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] sum_src;
        logic             c_src;
        logic             v_src;
        logic [SW-1:0]    s_sl;
        logic [WIDTH-1:0] s_top;
        logic [NG:0]      cg;
        logic [NG-1:0]    c3g;
        logic             vld_q;
        logic             cy_q;
        logic [WIDTH-1:0] sum_q;

        if (k == 0) begin : g_src
            assign a_src   = bus.a;
            assign b_src   = b_eff;
            assign sum_src = '0;
            assign c_src   = cin_eff;
            assign v_src   = bus.in_valid;
        end else begin : g_src
            assign a_src   = g_stg[k-1].g_fwd.a_q;
            assign b_src   = g_stg[k-1].g_fwd.b_q;
            assign sum_src = g_stg[k-1].sum_q;
            assign c_src   = g_stg[k-1].cy_q;
            assign v_src   = g_stg[k-1].vld_q;
        end

        assign cg[0] = c_src;
        for (genvar g = 0; g < NG; g++) begin : g_grp
            cla_grp4 u_grp (
                .a_i  (a_src[4*g +: 4]),
                .b_i  (b_src[4*g +: 4]),
                .ci_i (cg[g]),
                .s_o  (s_sl[4*g +: 4]),
                .co_o (cg[g+1]),
                .c3_o (c3g[g])
            );
        end

        assign s_top = WIDTH'(s_sl) << (WIDTH - SW);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (en) begin
                vld_q <= v_src;
                cy_q  <= cg[NG];
                sum_q <= (sum_src >> SW) | s_top;
            end
        end

        // Upper operand slices still waiting for their stage.
        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_src >> SW;
                    b_q <= b_src >> SW;
                end
            end
        end

        if (k == STAGES - 1) begin : g_msb
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cmsb_q <= 1'b0;
                end else if (en) begin
                    cmsb_q <= c3g[NG-1];
                end
            end
        end
    end

    assign out_vld       = g_stg[STAGES-1].vld_q;
    assign cy_fin        = g_stg[STAGES-1].cy_q;
    assign s_fin         = g_stg[STAGES-1].sum_q;
    assign bus.out_valid = out_vld;
    assign bus.s         = s_fin;

    // Flags read as zero whenever no result is presented (including straight out of reset).
    always_comb begin
        bus.flags = '0;
        if (out_vld) begin
            bus.flags.n = s_fin[WIDTH-1];
            bus.flags.z = ~|s_fin;
            bus.flags.c = cy_fin;
            bus.flags.v = cmsb_q ^ cy_fin;
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and model-checked bench for cla_pipe_addsub, plus width/depth sweep instances.
module tb_cla_pipe_addsub;
    import alu_pkg::*;

    localparam int unsigned MS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic sweep_go = 1'b0;
    int   sweep_done = 0;

    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(32)) bus ();

    cla_pipe_addsub #(.WIDTH(32), .STAGES(MS)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide addition, result {s (64b), n, z, c, v}.
    function automatic logic [67:0] model(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic ci, input int w);
        logic [64:0] mask, lmask, bx, full, low, sx;
        logic        cin;
        mask  = (65'd1 << w) - 65'd1;
        lmask = mask >> 1;
        bx    = {1'b0, (op[0] ? ~b : b)} & mask;
        cin   = op[1] ? ci : op[0];
        full  = ({1'b0, a} & mask) + bx + 65'(cin);
        low   = ({1'b0, a} & lmask) + (bx & lmask) + 65'(cin);
        sx    = full & mask;
        return {sx[63:0], sx[w-1], (sx == 65'd0), full[w], full[w] ^ low[w-1]};
    endfunction

    task automatic run_vec(input string tag, input op_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic ci, input logic [31:0] es,
                           input logic [3:0] ef);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.ci       = ci;
        for (int k = 1; k <= int'(MS); k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (k < int'(MS)) chk({tag, "_early"}, bus.out_valid, 1'b0);
        end
        chk({tag, "_vld"}, bus.out_valid, 1'b1);
        chk({tag, "_s"}, bus.s, es);
        chk({tag, "_nzcv"}, bus.flags, ef);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  sa [12];
        logic [31:0]  sbv [12];
        op_e          sop [12];
        logic         sci [12];
        logic [67:0]  q [$];
        logic [MS-1:0] pv;
        logic         ordy, iv, en_m;
        int           idx, ncons;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = OP_ADD;
        bus.ci        = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_ovld", bus.out_valid, 1'b0);
        chk("rst_s", bus.s, 32'h0);
        chk("rst_flags", bus.flags, 4'b0000);
        chk("rst_irdy", bus.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        run_vec("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001);
        run_vec("sub_eq", OP_SUB, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 4'b0110);
        run_vec("sub_ovf", OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0011);
        run_vec("adc_wrap", OP_ADC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0110);
        run_vec("sbc_brw", OP_SBC, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 4'b1000);
        run_vec("add_ign_ci", OP_ADD, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0003, 4'b0000);
        run_vec("adc_ci0", OP_ADC, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 4'b0000);
        run_vec("sub_neg", OP_SUB, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 4'b1000);

        // Streaming with a 3-cycle consumer stall; pv tracks expected stage valids.
        for (int i = 0; i < 12; i++) begin
            sa[i]  = $urandom;
            sbv[i] = $urandom;
            sop[i] = op_e'($urandom_range(3, 0));
            sci[i] = 1'($urandom_range(1, 0));
        end
        pv    = '0;
        idx   = 0;
        ncons = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            ordy          = !(cyc >= 8 && cyc <= 10);
            iv            = (idx < 12);
            bus.out_ready = ordy;
            bus.in_valid  = iv;
            if (iv) begin
                bus.a  = sa[idx];
                bus.b  = sbv[idx];
                bus.op = sop[idx];
                bus.ci = sci[idx];
            end
            #1;
            en_m = !(pv[MS-1] && !ordy);
            chk("st_ovld", bus.out_valid, pv[MS-1]);
            chk("st_irdy", bus.in_ready, en_m);
            if (pv[MS-1] && q.size() > 0) chk("st_res", {bus.s, bus.flags}, q[0]);
            if (en_m) begin
                if (pv[MS-1] && ordy) begin
                    void'(q.pop_front());
                    ncons++;
                end
                pv = (pv << 1) | MS'(iv);
                if (iv) begin
                    q.push_back(model(sop[idx], 64'(sa[idx]), 64'(sbv[idx]), sci[idx], 32));
                    idx++;
                end
            end
        end
        chk("st_cons", ncons, 12);
        chk("st_left", q.size(), 0);

        // Asynchronous reset with two operations in flight.
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h1111_1111;
        @(negedge clk);
        bus.a        = 32'h0F0F_0F0F;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rf_pre_vld", bus.out_valid, 1'b1);
        chk("rf_pre_s", bus.s, 32'h2345_6789);
        #2;
        rst = 1'b1;
        #1;
        chk("rf_ovld", bus.out_valid, 1'b0);
        chk("rf_s", bus.s, 32'h0);
        chk("rf_flags", bus.flags, 4'b0000);
        chk("rf_irdy", bus.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rf_stale", bus.out_valid, 1'b0);
        end

        sweep_go = 1'b1;
        for (int i = 0; i < 2000 && sweep_done < 3; i++) @(negedge clk);
        chk("sweep_done", sweep_done, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Width/depth sweep: one operation at a time, exact latency and model check.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int unsigned W = (gi == 0) ? 8 : (gi == 1) ? 64 : 16;
        localparam int unsigned S = (gi == 0) ? 2 : (gi == 1) ? 4 : 1;

        cla_pipe_addsub_if #(.WIDTH(W)) sb ();

        cla_pipe_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (sb)
        );

        initial begin
            logic [W-1:0] cv [4];
            logic [W-1:0] va, vb;
            logic [1:0]   vo;
            logic         vc;

            sb.in_valid  = 1'b0;
            sb.a         = '0;
            sb.b         = '0;
            sb.op        = OP_ADD;
            sb.ci        = 1'b0;
            sb.out_ready = 1'b1;
            cv[0] = '0;
            cv[1] = '1;
            cv[2] = {1'b1, {(W-1){1'b0}}};
            cv[3] = ~cv[2];
            wait (sweep_go);
            for (int i = 0; i < 24; i++) begin
                if (i < 16) begin
                    va = cv[i % 4];
                    vb = cv[i / 4];
                    vo = 2'(i + i / 4);
                    vc = 1'(i);
                end else begin
                    va = W'({$urandom, $urandom});
                    vb = W'({$urandom, $urandom});
                    vo = 2'($urandom_range(3, 0));
                    vc = 1'($urandom_range(1, 0));
                end
                @(negedge clk);
                sb.in_valid = 1'b1;
                sb.a        = va;
                sb.b        = vb;
                sb.op       = op_e'(vo);
                sb.ci       = vc;
                for (int k = 1; k <= int'(S); k++) begin
                    @(negedge clk);
                    sb.in_valid = 1'b0;
                    if (k < int'(S)) chk($sformatf("sw%0d_early", W), sb.out_valid, 1'b0);
                end
                chk($sformatf("sw%0d_vld", W), sb.out_valid, 1'b1);
                chk($sformatf("sw%0d_res_%0d", W, i), {sb.s, sb.flags},
                    model(vo, 64'(va), 64'(vb), vc, int'(W)));
            end
            sweep_done++;
        end
    end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor: the next generation of the team's 32-bit CLA-with-overflow adder. It adds width and pipeline-depth parameters, add/sub/add-with-carry/sub-with-borrow modes, a full N/Z/C/V flag set, and a valid/ready handshake with backpressure. It sits in the ALU datapath between operand select and result writeback.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4*STAGES
- STAGES, 2, pipeline stages, 1..WIDTH/4; each stage resolves WIDTH/STAGES bits
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand transfer request
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC
- ci  in  1  carry-in; used only by ADC/SBC
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  result
- n, z, c, v  out  1 each  negative, zero, carry-out, signed overflow

## Operation
- Effective operation is a + b' + cin:
  - ADD: b'=b, cin=0
  - SUB: b'=~b, cin=1
  - ADC: b'=b, cin=ci
  - SBC: b'=~b, cin=ci, where ci=1 means no borrow
- c = carry out of bit WIDTH-1. For SUB/SBC, c=1 means no borrow (ARM convention).
- v = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- n = s[WIDTH-1]; z = (s == 0).
- Stage k adds slice k (WIDTH/STAGES bits) using 4-bit lookahead groups rippled by group carry.
  - Its carry-in is the registered carry from stage k-1.
  - Unprocessed upper operand slices are carried forward in pipeline registers.
  - Already-computed lower sum slices are carried forward (skewed pipeline).
- The last stage also registers the carry into the MSB for v.
- Flags are computed from final registered values; z is a full-width reduction on the final sum.
- Each stage has a valid bit. Global advance en = !(out_valid && !out_ready); in_ready = en.
- When en=0, every stage register holds. Bubbles are not compressed.
- A transfer occurs when in_valid && in_ready. The stage-0 valid bit loads in_valid when en=1.
- Data registers may load when their valid bit is 0. Outputs are defined only while out_valid=1.

## Timing
- Latency is STAGES cycles: operands accepted at edge t give out_valid=1 after edge t+STAGES, provided en stays 1.
- Throughput is one result per cycle with out_ready held high.
- in_ready is combinational from out_ready and out_valid (no other inputs).
- Consumer stall: s, n, z, c, v and out_valid stay stable until the cycle in which out_ready=1.
- Input acceptance and output drain in the same cycle with a full pipeline is legal; no bubble is inserted.
- Reset, asynchronous, is allowed at any time including mid-operation:
  - all valid bits go to 0 and all data/flag registers go to 0;
  - out_valid=0, s=0, n=z=c=v=0; in_ready=1 immediately after reset;
  - in-flight operations are discarded.
- STAGES=1 degenerates to one registered full-width CLA, with 1-cycle latency.

## Structure
- Shared package `alu_pkg` holds:
  - the op encodings (OP_ADD, OP_SUB, OP_ADC, OP_SBC);
  - a flag bundle typedef {n,z,c,v}.
- Sub-module `cla_grp4` is a combinational 4-bit lookahead group with inputs a, b, ci and outputs s, co, c3 (carry into bit 3). It is instantiated WIDTH/4 times via generate.
- Elaboration-time checks: assert WIDTH % (4*STAGES) == 0 and STAGES >= 1.

## Test plan
- Defaults, ADD 0x7FFFFFFF + 0x00000001 -> two cycles later s=0x80000000, n=1 z=0 c=0 v=1.
- SUB 0x00000005 - 0x00000005 -> s=0, z=1 c=1 v=0; SUB 0x80000000 - 0x00000001 -> s=0x7FFFFFFF, c=1 v=1.
- ADC 0xFFFFFFFF + 0 with ci=1 -> s=0, c=1 z=1 v=0; SBC 0 - 0 with ci=0 -> s=0xFFFFFFFF, c=0 n=1.
- Back-to-back stream of 8 random ops with out_ready=1 -> 8 consecutive valid results in order, matching a reference model; then hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, no loss or duplication after release.
- Assert reset with 2 ops in flight -> out_valid=0 and all outputs 0 asynchronously; after release, no stale results appear.
- Sweep WIDTH=8/STAGES=2, WIDTH=64/STAGES=4, WIDTH=16/STAGES=1 with random plus corner operands (0, all-ones, MIN, MAX) -> flags and sums match the model at latency STAGES.
